uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive-byte buffer depth (power of 2, 2..16).
REQ-002 SHALL have parameter RECOVER_CYC, default 4, number of cycles rx_rst is held after a frame error (1..15).
REQ-003 SHALL have parameter ERR_CNT_W, default 8, width of the frame-error counter.
REQ-004 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rx_rst_n  in  1  synchronous, active-low reset.
REQ-006 SHALL have port ctrl_en  in  1  software receive enable.
REQ-007 SHALL have port clr  in  1  one-cycle pulse; clears overflow and err_count.
REQ-008 SHALL have port rx_done  in  1  frame-done flag from the receiver datapath.
REQ-009 SHALL have port rx_err  in  1  frame-error flag from the receiver datapath.
REQ-010 SHALL have port rx_busy  in  1  receiver-busy flag from the receiver datapath.
REQ-011 SHALL have port rx_data  in  8  received byte from the receiver datapath.
REQ-012 SHALL have port rx_en  out  1  enable to the receiver datapath.
REQ-013 SHALL have port rx_rst  out  1  active-high synchronous clear to the receiver datapath.
REQ-014 SHALL have port m_data  out  8  byte at the buffer head.
REQ-015 SHALL have port m_valid  out  1  buffer non-empty.
REQ-016 SHALL have port m_ready  in  1  consumer accepts m_data.
REQ-017 SHALL have port fifo_count  out  $clog2(FIFO_DEPTH)+1  current buffer occupancy.
REQ-018 SHALL have port overflow  out  1  sticky flag; a byte was dropped.
REQ-019 SHALL have port err_count  out  ERR_CNT_W  saturating count of frame errors.

Function
REQ-020 SHALL implement the states IDLE, LISTEN, DRAIN and RECOVER.
REQ-021 IDLE SHALL drive rx_en=0 and rx_rst=0, and SHALL go to LISTEN when ctrl_en=1.
REQ-022 LISTEN SHALL drive rx_en=1; when ctrl_en=0 it SHALL go to IDLE if rx_busy=0, else to DRAIN.
REQ-023 DRAIN SHALL hold rx_en=1 until rx_busy=0 or an rx_err rising edge, then SHALL go to IDLE; the final byte SHALL be captured.
REQ-024 A rising edge of rx_done (registered previous value 0, current 1) in LISTEN/DRAIN SHALL push rx_data into the buffer on that cycle.
REQ-025 A rising edge of rx_err in LISTEN/DRAIN SHALL go to RECOVER, SHALL increment err_count (saturating at all-ones), and SHALL take priority over a same-cycle done edge, whose byte is discarded.
REQ-026 RECOVER SHALL drive rx_en=0 and rx_rst=1 for exactly RECOVER_CYC cycles, then SHALL go to LISTEN if ctrl_en=1, else to IDLE.
REQ-027 Buffer handshake: pop when m_valid and m_ready; m_data SHALL be the head byte combinationally from storage; m_valid = (fifo_count != 0).
REQ-028 A push while full, with no same-cycle pop, SHALL drop the byte and set overflow; a push and pop together when full SHALL both occur, leaving the count unchanged.
REQ-029 A push and pop together when empty SHALL push only.
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH, and fifo_count SHALL never exceed FIFO_DEPTH.
REQ-031 clr SHALL zero overflow and err_count next cycle; a same-cycle set or increment SHALL lose to clr.
REQ-032 Buffer pops SHALL continue in every state.

Reset
REQ-033 rx_rst_n=0 at a clock edge SHALL force IDLE, empty the buffer, and set rx_en=0, rx_rst=0, m_valid=0, fifo_count=0, overflow=0, err_count=0, with the edge-detect registers at 0; m_data is don't-care.
REQ-034 Reset mid-frame or mid-RECOVER SHALL abort immediately with no byte captured.

Structure
REQ-035 SHALL place the state encoding enum and the default parameter constants in shared package uart_pkg.
REQ-036 SHALL implement the byte buffer as sub-module uart_sync_fifo (parameterised width/depth, with count, full and empty outputs); the FSM, edge detect and counters SHALL live in uart_rx_ctrl.

Verification
REQ-037 ctrl_en=1, rx_done edge with rx_data=0xA5, m_ready=0 -> fifo_count=1, m_valid=1, m_data=0xA5; m_ready=1 for one cycle -> fifo_count=0.
REQ-038 Five done edges (0x01..0x05), m_ready=0, FIFO_DEPTH=4 -> fifo_count=4, overflow=1, pops return 0x01..0x04.
REQ-039 rx_err edge with a simultaneous done edge -> nothing pushed, err_count=1, rx_rst=1 for 4 cycles, then LISTEN with rx_en=1.
REQ-040 ctrl_en dropped while rx_busy=1, done edge with 0x3C, then busy low -> 0x3C captured, then IDLE with rx_en=0.
REQ-041 Full buffer, push and pop in the same cycle -> fifo_count stays 4, overflow stays 0; 256 errors -> err_count=255; clr -> 0.
REQ-042 rx_rst_n=0 in RECOVER with 3 bytes buffered -> next cycle all outputs hold their REQ-033 values.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and default constants for the UART receive controller.
//   rx_state_e : controller state encoding
//   DEF_*      : default parameter values for uart_rx_ctrl
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LISTEN  = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_RECOVER = 2'd3
    } rx_state_e;

    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_RECOVER_CYC = 4;
    localparam int DEF_ERR_CNT_W   = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
//   Single-clock byte buffer with first-word-fall-through read port.
//   clk, rst_n            : clock, synchronous active-low reset
//   push, push_data       : write request and data (ignored when full unless popping)
//   pop                   : read request (ignored when empty)
//   head_data             : oldest stored entry, read combinationally from storage
//   count, full, empty    : occupancy status
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full buffer still accepts a
    // simultaneous push. An empty buffer cannot pop, so push+pop is push only.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Sequencing controller for a UART receiver datapath: enables/clears the
//   datapath, captures completed bytes into a buffer and counts frame errors.
//   clk, rx_rst_n              : clock, synchronous active-low reset
//   ctrl_en, clr               : software enable, clear of overflow/err_count
//   rx_done, rx_err, rx_busy   : status flags from the datapath
//   rx_data                    : received byte from the datapath
//   rx_en, rx_rst              : registered enable and clear to the datapath
//   m_data, m_valid, m_ready   : byte output handshake (buffer head)
//   fifo_count, overflow       : buffer occupancy, sticky dropped-byte flag
//   err_count                  : saturating frame-error count
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_IDLE    | datapath disabled, waiting for ctrl_en
//   ST_LISTEN  | datapath enabled, capturing bytes
//   ST_DRAIN   | ctrl_en dropped mid-frame; wait for the frame to finish
//   ST_RECOVER | frame error; datapath held in clear for RECOVER_CYC cycles
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int RECOVER_CYC = DEF_RECOVER_CYC,
    parameter int ERR_CNT_W   = DEF_ERR_CNT_W
) (
    input  logic                          clk,
    input  logic                          rx_rst_n,
    input  logic                          ctrl_en,
    input  logic                          clr,
    input  logic                          rx_done,
    input  logic                          rx_err,
    input  logic                          rx_busy,
    input  logic [7:0]                    rx_data,
    output logic                          rx_en,
    output logic                          rx_rst,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [ERR_CNT_W-1:0]          err_count
);

    localparam logic [3:0] REC_LOAD = 4'(RECOVER_CYC - 1);

    rx_state_e            state_q, state_d;
    logic [3:0]           rec_cnt_q, rec_cnt_d;
    logic                 rx_en_q, rx_en_d;
    logic                 rx_rst_q, rx_rst_d;
    logic                 done_prev_q, done_prev_d;
    logic                 err_prev_q, err_prev_d;
    logic                 overflow_q, overflow_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic done_edge;
    logic err_edge;
    logic active;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;

    assign done_edge = rx_done & ~done_prev_q;
    assign err_edge  = rx_err & ~err_prev_q;
    assign active    = (state_q == ST_LISTEN) || (state_q == ST_DRAIN);
    // An error edge discards any byte completing in the same cycle.
    assign push      = active & done_edge & ~err_edge;
    assign pop       = m_valid & m_ready;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rx_rst_n),
        .push      (push),
        .push_data (rx_data),
        .pop       (pop),
        .head_data (m_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_valid = ~fifo_empty;

    always_comb begin
        state_d   = state_q;
        rec_cnt_d = rec_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_en) begin
                    state_d = ST_LISTEN;
                end
            end
            ST_LISTEN: begin
                if (err_edge) begin
                    state_d   = ST_RECOVER;
                    rec_cnt_d = REC_LOAD;
                end else if (!ctrl_en) begin
                    state_d = rx_busy ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // An error while draining still clears the datapath; RECOVER
                // then lands in IDLE unless software has re-enabled.
                if (err_edge) begin
                    state_d   = ST_RECOVER;
                    rec_cnt_d = REC_LOAD;
                end else if (!rx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECOVER: begin
                if (rec_cnt_q == 4'd0) begin
                    state_d = ctrl_en ? ST_LISTEN : ST_IDLE;
                end else begin
                    rec_cnt_d = rec_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they track state_q.
        rx_en_d  = (state_d == ST_LISTEN) || (state_d == ST_DRAIN);
        rx_rst_d = (state_d == ST_RECOVER);
    end

    always_comb begin
        done_prev_d = rx_done;
        err_prev_d  = rx_err;

        overflow_d = overflow_q;
        if (clr) begin
            overflow_d = 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end

        err_count_d = err_count_q;
        if (clr) begin
            err_count_d = '0;
        end else if (active && err_edge && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rx_rst_n) begin
            state_q   <= ST_IDLE;
            rec_cnt_q <= 4'd0;
            rx_en_q   <= 1'b0;
            rx_rst_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rec_cnt_q <= rec_cnt_d;
            rx_en_q   <= rx_en_d;
            rx_rst_q  <= rx_rst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rx_rst_n) begin
            done_prev_q <= 1'b0;
            err_prev_q  <= 1'b0;
            overflow_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            done_prev_q <= done_prev_d;
            err_prev_q  <= err_prev_d;
            overflow_q  <= overflow_d;
            err_count_q <= err_count_d;
        end
    end

    assign rx_en     = rx_en_q;
    assign rx_rst    = rx_rst_q;
    assign overflow  = overflow_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
//   Directed bench for uart_rx_ctrl. Accepted bytes are queued as they are
//   issued; a negedge monitor compares every handshake pop against the queue.
module tb_uart_rx_ctrl;

    logic       clk;
    logic       rx_rst_n;
    logic       ctrl_en;
    logic       clr;
    logic       rx_done;
    logic       rx_err;
    logic       rx_busy;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       rx_rst;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    uart_rx_ctrl #(
        .FIFO_DEPTH  (4),
        .RECOVER_CYC (4),
        .ERR_CNT_W   (8)
    ) dut (
        .clk        (clk),
        .rx_rst_n   (rx_rst_n),
        .ctrl_en    (ctrl_en),
        .clr        (clr),
        .rx_done    (rx_done),
        .rx_err     (rx_err),
        .rx_busy    (rx_busy),
        .rx_data    (rx_data),
        .rx_en      (rx_en),
        .rx_rst     (rx_rst),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs only change 1 time unit after a rising edge, so negedge values
    // are exactly what the DUT sees at the next rising edge.
    always @(negedge clk) begin
        if (rx_rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected no pop", m_data);
            end else begin
                chk("pop_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic done_pulse(input logic [7:0] d, input bit accepted);
        rx_data = d;
        rx_done = 1'b1;
        if (accepted) exp_q.push_back(d);
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic drain(input int n);
        m_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
        m_ready = 1'b0;
    endtask

    task automatic wait_listen();
        int k;
        k = 0;
        while (!rx_en && k < 20) begin
            tick();
            k++;
        end
        if (!rx_en) begin
            n_checks++;
            n_fail++;
            $display("FAIL recover_timeout: got rx_en=%0b expected 1", rx_en);
        end
    endtask

    task automatic err_pulse();
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        wait_listen();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        rx_rst_n = 1'b0;
        ctrl_en  = 1'b0;
        clr      = 1'b0;
        rx_done  = 1'b0;
        rx_err   = 1'b0;
        rx_busy  = 1'b0;
        rx_data  = 8'h00;
        m_ready  = 1'b0;
        tick();
        tick();
        chk("rst_rx_en",      {31'd0, rx_en},      32'd0);
        chk("rst_rx_rst",     {31'd0, rx_rst},     32'd0);
        chk("rst_m_valid",    {31'd0, m_valid},    32'd0);
        chk("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
        chk("rst_overflow",   {31'd0, overflow},   32'd0);
        chk("rst_err_count",  {24'd0, err_count},  32'd0);

        rx_rst_n = 1'b1;
        ctrl_en  = 1'b1;
        tick();
        chk("listen_rx_en", {31'd0, rx_en}, 32'd1);

        // single byte capture and pop
        done_pulse(8'hA5, 1'b1);
        chk("one_count",   {29'd0, fifo_count}, 32'd1);
        chk("one_m_valid", {31'd0, m_valid},    32'd1);
        chk("one_m_data",  {24'd0, m_data},     32'hA5);
        drain(1);
        chk("one_popped_count", {29'd0, fifo_count}, 32'd0);

        // overflow: fifth byte dropped
        for (int i = 1; i <= 5; i++) done_pulse(8'(i), i <= 4);
        chk("ovf_count", {29'd0, fifo_count}, 32'd4);
        chk("ovf_flag",  {31'd0, overflow},   32'd1);
        drain(4);
        chk("ovf_drained_count", {29'd0, fifo_count}, 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovf_clr", {31'd0, overflow}, 32'd0);

        // error edge beats a simultaneous done edge
        rx_data = 8'hEE;
        rx_done = 1'b1;
        rx_err  = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_err  = 1'b0;
        chk("err_count_1",  {24'd0, err_count},  32'd1);
        chk("err_no_push",  {29'd0, fifo_count}, 32'd0);
        chk("err_rx_en",    {31'd0, rx_en},      32'd0);
        hi = rx_rst ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rx_rst) hi++;
            else break;
        end
        chk("recover_cycles", hi, 32'd4);
        chk("recover_listen", {31'd0, rx_en}, 32'd1);

        // drain: ctrl_en drops while busy, final byte still captured
        rx_busy = 1'b1;
        ctrl_en = 1'b0;
        tick();
        chk("drain_rx_en", {31'd0, rx_en}, 32'd1);
        done_pulse(8'h3C, 1'b1);
        rx_busy = 1'b0;
        tick();
        chk("drain_idle_rx_en", {31'd0, rx_en},      32'd0);
        chk("drain_count",      {29'd0, fifo_count}, 32'd1);
        drain(1);
        chk("drain_popped", {29'd0, fifo_count}, 32'd0);

        // full buffer with simultaneous push and pop
        ctrl_en = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) done_pulse(8'h10 + 8'(i), 1'b1);
        chk("full_count", {29'd0, fifo_count}, 32'd4);
        rx_data = 8'h14;
        rx_done = 1'b1;
        m_ready = 1'b1;
        exp_q.push_back(8'h14);
        tick();
        rx_done = 1'b0;
        m_ready = 1'b0;
        tick();
        chk("pushpop_count",    {29'd0, fifo_count}, 32'd4);
        chk("pushpop_overflow", {31'd0, overflow},   32'd0);
        drain(4);
        chk("pushpop_drained", {29'd0, fifo_count}, 32'd0);

        // error counter saturation and clear
        wait_listen();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("err_clr_start", {24'd0, err_count}, 32'd0);
        for (int i = 0; i < 255; i++) err_pulse();
        chk("err_count_255", {24'd0, err_count}, 32'd255);
        err_pulse();
        chk("err_saturate", {24'd0, err_count}, 32'd255);
        clr = 1'b1;
        rx_err = 1'b1;
        tick();
        clr = 1'b0;
        rx_err = 1'b0;
        chk("err_clr_wins", {24'd0, err_count}, 32'd0);
        wait_listen();

        // reset while in RECOVER with bytes buffered
        for (int i = 0; i < 3; i++) done_pulse(8'h21 + 8'(i), 1'b1);
        chk("pre_rst_count", {29'd0, fifo_count}, 32'd3);
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        chk("pre_rst_rx_rst",    {31'd0, rx_rst},    32'd1);
        chk("pre_rst_err_count", {24'd0, err_count}, 32'd1);
        tick();
        rx_rst_n = 1'b0;
        exp_q.delete();
        tick();
        chk("mid_rst_rx_en",      {31'd0, rx_en},      32'd0);
        chk("mid_rst_rx_rst",     {31'd0, rx_rst},     32'd0);
        chk("mid_rst_m_valid",    {31'd0, m_valid},    32'd0);
        chk("mid_rst_fifo_count", {29'd0, fifo_count}, 32'd0);
        chk("mid_rst_overflow",   {31'd0, overflow},   32'd0);
        chk("mid_rst_err_count",  {24'd0, err_count},  32'd0);
        ctrl_en  = 1'b0;
        rx_rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, rx_en}, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
